instruction_sequencer: RTL and testbench
========================================

# instruction_sequencer

Multi-cycle control FSM that sits directly upstream of the datapath. It latches `current_instruction`, decodes it, and drives every datapath control input: ALU operation and operand selects, write-back source, memory/stack store strobes, PC increment and VGA selects. It also resolves conditional jumps from `zeroflag`/`signflag`, halts on `HALT`, and traps on illegal opcodes.

## Interface
- `ALU_PASS`, default 4'h0: ALU opcode for which the ALU output `c` equals input `a`.
- `clock` in 1: system clock. The sequencer updates on posedge; the datapath samples on the following negedge.
- `resetn` in 1: asynchronous, active-low reset.
- `current_instruction` in 16: word at PC, from the datapath.
- `zeroflag`, `signflag` in 16 each: per-register flags, bit i belongs to register i.
- `program_counter_increment` out 1: adds 1 to PC at the datapath negedge.
- `alu_op` out 4.
- `alu_a_select`, `alu_b_select`, `alu_out_select` out 4 each.
- `alu_a_source`, `alu_b_source` out 1 each: 1 selects the `*_altern` input.
- `alu_a_altern`, `alu_b_altern` out 16 each: immediate operands.
- `alu_load_src` out 2: 00 none, 01 ALU, 10 memory, 11 stack.
- `alu_store_to_mem`, `alu_store_to_stk` out 1 each: single-cycle store strobes.
- `vga_color_select`, `vga_coord_select` out 4 each; `vga_draw` out 1: single-cycle plot strobe.
- `halted`, `trapped` out 1 each: sticky status.
- `retired` out 16: count of completed instructions; wraps from 16'hFFFF to 0.

## Operation
- IR fields: op = IR[15:12], rd = IR[11:8], rs = IR[7:4], lo = IR[3:0].
- States:
  - FETCH: all controls 0; IR <= `current_instruction`; next state EXEC.
  - EXEC: decode per opcode below.
  - WAIT: load write-back.
  - HALT, TRAP: terminal until reset.
- Outputs are decoded from the registered state and IR only, so they are stable for the whole cycle. Any output not listed for a state is 0.
- Opcodes:
  - 0 HALT → HALT state.
  - 1 ALU: a=rd, b=rs, `alu_op`=lo, out=rd, load_src=01, inc=1.
  - 2 ALUI: as ALU but b_source=1, b_altern={12'b0,rs}.
  - 3 LDI: a_source=1, a_altern={8'b0,IR[7:0]}, alu_op=ALU_PASS, out=rd, load_src=01, inc=1.
  - 4 LD / 6 POP: EXEC drives a=rs, alu_op=ALU_PASS, load_src=00, next state WAIT. WAIT keeps the same address and drives out=rd, load_src=10 (LD) or 11 (POP), inc=1.
  - 5 ST / 7 PUSH: a=rs, alu_op=ALU_PASS, out=rd (value), `alu_store_to_mem` (ST) or `alu_store_to_stk` (PUSH)=1, inc=1.
  - 8 JZ / 9 JN: condition is `zeroflag[rd]` (JZ) or `signflag[rd]` (JN).
    - Taken: a=rs, alu_op=ALU_PASS, out=0, load_src=01, inc=0, so PC becomes reg[rs].
    - Not taken: inc=1 only.
  - A JMP: always-taken form of the jump encoding.
  - B DRAW: vga_color_select=rd, vga_coord_select=rs, vga_draw=1, inc=1.
  - C–F: illegal → TRAP.
- The flag index uses the flag value as sampled during EXEC.
- An instruction completes at the posedge ending its EXEC cycle (single-cycle ops), or its WAIT cycle (LD/POP). On completion: `retired` += 1, next state FETCH.
- HALT and TRAP do not increment PC or `retired`. They set `halted` or `trapped` respectively.
- Writes to register 0 via ALU/LDI/LD behave as jumps: the datapath adds `inc`. The sequencer still asserts inc=1 for these, so the PC lands at value+1.

## Timing
- Cycles per instruction: 2 (FETCH+EXEC); LD/POP take 3.
- Store and draw strobes are exactly 1 cycle wide. No back-to-back strobes, because FETCH intervenes.
- `current_instruction` must be valid by the posedge ending FETCH. It reflects the PC updated at the previous EXEC/WAIT negedge.
- Reset is asynchronous:
  - State goes to FETCH; IR, `retired`, `halted`, `trapped` go to 0.
  - All control outputs read 0 while `resetn`=0.
- Reset asserted mid-LD (in WAIT) aborts the load with no write-back. The first FETCH after release occurs on the first posedge with `resetn`=1.

## Configuration
- `SEQUENCER_STEP_EN`
  - Defined: adds input `step` (1 bit), synchronised by 2 flops. FETCH holds, latching nothing, until a rising edge of the synchronised `step`; then one instruction executes. Extra latency: 3 cycles after the edge.
  - Undefined: FETCH always proceeds; the `step` port is absent.

## Test plan
- Reset, then LDI r3,#0x5A → reg3 = 16'h005A, PC = 1, `retired` = 1 after 2 cycles.
- ALU r3,r4 with lo=ALU_PASS, reg4 = 16'h1234 → reg3 = 16'h1234.
- ST r2→[r1] (r1=16'h0040) → `alu_store_to_mem` high exactly 1 cycle with `alu_output`=16'h0040. Following LD r5,[r1] takes 3 cycles, reg5 = stored value.
- JZ r6,r7 with reg6=0, reg7=16'h0010 → PC = 16'h0010, `retired` += 1. With reg6=1 → PC = old PC + 1.
- Opcode 4'hD → `trapped` = 1; PC and `retired` frozen for 20 cycles. Reset clears all state.
- Reset asserted during WAIT of a LD → destination unchanged, outputs 0 immediately. FETCH resumes at PC 0 after release.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer: multi-cycle control FSM driving the datapath.
// FETCH latches the instruction, EXEC decodes it, WAIT completes LD/POP
// write-back, HALT/TRAP are terminal until reset. All control outputs are
// registered so they hold steady for the whole cycle the datapath samples.
// Optional build macro: SEQUENCER_STEP_EN adds a synchronised single-step
// input that gates each FETCH.
module instruction_sequencer #(
    parameter logic [3:0] ALU_PASS = 4'h0
) (
    input  logic        clock,
    input  logic        resetn,
`ifdef SEQUENCER_STEP_EN
    input  logic        step,
`endif
    input  logic [15:0] current_instruction,
    input  logic [15:0] zeroflag,
    input  logic [15:0] signflag,
    output logic        program_counter_increment,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a_select,
    output logic [3:0]  alu_b_select,
    output logic [3:0]  alu_out_select,
    output logic        alu_a_source,
    output logic        alu_b_source,
    output logic [15:0] alu_a_altern,
    output logic [15:0] alu_b_altern,
    output logic [1:0]  alu_load_src,
    output logic        alu_store_to_mem,
    output logic        alu_store_to_stk,
    output logic [3:0]  vga_color_select,
    output logic [3:0]  vga_coord_select,
    output logic        vga_draw,
    output logic        halted,
    output logic        trapped,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT,
        S_TRAP
    } state_t;

    typedef enum logic [3:0] {
        OP_HALT = 4'h0,
        OP_ALU  = 4'h1,
        OP_ALUI = 4'h2,
        OP_LDI  = 4'h3,
        OP_LD   = 4'h4,
        OP_ST   = 4'h5,
        OP_POP  = 4'h6,
        OP_PUSH = 4'h7,
        OP_JZ   = 4'h8,
        OP_JN   = 4'h9,
        OP_JMP  = 4'hA,
        OP_DRAW = 4'hB
    } opcode_t;

    typedef struct packed {
        logic        inc;
        logic [3:0]  alu_op;
        logic [3:0]  a_sel;
        logic [3:0]  b_sel;
        logic [3:0]  out_sel;
        logic        a_src;
        logic        b_src;
        logic [15:0] a_alt;
        logic [15:0] b_alt;
        logic [1:0]  load_src;
        logic        st_mem;
        logic        st_stk;
        logic [3:0]  color;
        logic [3:0]  coord;
        logic        draw;
    } ctl_t;

    state_t      state;
    logic [15:0] ir;
    ctl_t        ctl;
    logic        fetch_go;

    // Control word for the EXEC cycle of instruction ins.
    function automatic ctl_t exec_ctl(input logic [15:0] ins,
                                      input logic zf, input logic sf);
        ctl_t c;
        logic taken;
        c     = '0;
        taken = 1'b0;
        case (ins[15:12])
            OP_ALU: begin
                c.a_sel    = ins[11:8];
                c.b_sel    = ins[7:4];
                c.alu_op   = ins[3:0];
                c.out_sel  = ins[11:8];
                c.load_src = 2'b01;
                c.inc      = 1'b1;
            end
            OP_ALUI: begin
                c.a_sel    = ins[11:8];
                c.b_src    = 1'b1;
                c.b_alt    = {12'b0, ins[7:4]};
                c.alu_op   = ins[3:0];
                c.out_sel  = ins[11:8];
                c.load_src = 2'b01;
                c.inc      = 1'b1;
            end
            OP_LDI: begin
                c.a_src    = 1'b1;
                c.a_alt    = {8'b0, ins[7:0]};
                c.alu_op   = ALU_PASS;
                c.out_sel  = ins[11:8];
                c.load_src = 2'b01;
                c.inc      = 1'b1;
            end
            OP_LD, OP_POP: begin
                c.a_sel  = ins[7:4];
                c.alu_op = ALU_PASS;
            end
            OP_ST, OP_PUSH: begin
                c.a_sel   = ins[7:4];
                c.alu_op  = ALU_PASS;
                c.out_sel = ins[11:8];
                c.st_mem  = (ins[15:12] == OP_ST);
                c.st_stk  = (ins[15:12] == OP_PUSH);
                c.inc     = 1'b1;
            end
            OP_JZ, OP_JN, OP_JMP: begin
                taken = (ins[15:12] == OP_JMP) ||
                        ((ins[15:12] == OP_JZ) && zf) ||
                        ((ins[15:12] == OP_JN) && sf);
                if (taken) begin
                    c.a_sel    = ins[7:4];
                    c.alu_op   = ALU_PASS;
                    c.out_sel  = 4'd0;
                    c.load_src = 2'b01;
                end else begin
                    c.inc = 1'b1;
                end
            end
            OP_DRAW: begin
                c.color = ins[11:8];
                c.coord = ins[7:4];
                c.draw  = 1'b1;
                c.inc   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Control word for the WAIT cycle of LD/POP: same address, write back.
    function automatic ctl_t wait_ctl(input logic [15:0] ins);
        ctl_t c;
        c          = '0;
        c.a_sel    = ins[7:4];
        c.alu_op   = ALU_PASS;
        c.out_sel  = ins[11:8];
        c.load_src = (ins[15:12] == OP_LD) ? 2'b10 : 2'b11;
        c.inc      = 1'b1;
        return c;
    endfunction

`ifdef SEQUENCER_STEP_EN
    logic step_meta, step_sync, step_prev, step_pend;

    // Two-flop synchroniser plus rising-edge detect; a pending request is
    // held until FETCH consumes it so an edge seen mid-instruction is kept.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            step_meta <= 1'b0;
            step_sync <= 1'b0;
            step_prev <= 1'b0;
            step_pend <= 1'b0;
        end else begin
            step_meta <= step;
            step_sync <= step_meta;
            step_prev <= step_sync;
            if (step_sync && !step_prev)
                step_pend <= 1'b1;
            else if (state == S_FETCH)
                step_pend <= 1'b0;
        end
    end

    assign fetch_go = step_pend;
`else
    assign fetch_go = 1'b1;
`endif

    // Main sequencer: state, IR, registered controls and status.
    // EXEC controls are computed at the FETCH->EXEC edge; flags sampled there
    // equal those during EXEC because the datapath writes nothing in FETCH.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state   <= S_FETCH;
            ir      <= '0;
            ctl     <= '0;
            retired <= '0;
            halted  <= 1'b0;
            trapped <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    ctl <= '0;
                    if (fetch_go) begin
                        ir    <= current_instruction;
                        state <= S_EXEC;
                        ctl   <= exec_ctl(current_instruction,
                                          zeroflag[current_instruction[11:8]],
                                          signflag[current_instruction[11:8]]);
                    end
                end
                S_EXEC: begin
                    ctl <= '0;
                    case (ir[15:12])
                        OP_HALT: begin
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end
                        OP_LD, OP_POP: begin
                            state <= S_WAIT;
                            ctl   <= wait_ctl(ir);
                        end
                        OP_ALU, OP_ALUI, OP_LDI, OP_ST, OP_PUSH,
                        OP_JZ, OP_JN, OP_JMP, OP_DRAW: begin
                            state   <= S_FETCH;
                            retired <= retired + 16'd1;
                        end
                        default: begin
                            state   <= S_TRAP;
                            trapped <= 1'b1;
                        end
                    endcase
                end
                S_WAIT: begin
                    ctl     <= '0;
                    state   <= S_FETCH;
                    retired <= retired + 16'd1;
                end
                S_HALT: ctl <= '0;
                S_TRAP: ctl <= '0;
                default: begin
                    ctl   <= '0;
                    state <= S_FETCH;
                end
            endcase
        end
    end

    assign program_counter_increment = ctl.inc;
    assign alu_op                    = ctl.alu_op;
    assign alu_a_select              = ctl.a_sel;
    assign alu_b_select              = ctl.b_sel;
    assign alu_out_select            = ctl.out_sel;
    assign alu_a_source              = ctl.a_src;
    assign alu_b_source              = ctl.b_src;
    assign alu_a_altern              = ctl.a_alt;
    assign alu_b_altern              = ctl.b_alt;
    assign alu_load_src              = ctl.load_src;
    assign alu_store_to_mem          = ctl.st_mem;
    assign alu_store_to_stk          = ctl.st_stk;
    assign vga_color_select          = ctl.color;
    assign vga_coord_select          = ctl.coord;
    assign vga_draw                  = ctl.draw;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Bench for instruction_sequencer: behavioural datapath (register file with
// r0 as PC, data memory, stack) driven by the DUT, plus an instruction-level
// reference model whose post-retire register snapshots form the scoreboard.
`timescale 1ns/1ps
module tb_instruction_sequencer;

    logic        clock = 1'b0;
    logic        resetn;
    logic [15:0] current_instruction, zeroflag, signflag;
    logic        program_counter_increment;
    logic [3:0]  alu_op, alu_a_select, alu_b_select, alu_out_select;
    logic        alu_a_source, alu_b_source;
    logic [15:0] alu_a_altern, alu_b_altern;
    logic [1:0]  alu_load_src;
    logic        alu_store_to_mem, alu_store_to_stk;
    logic [3:0]  vga_color_select, vga_coord_select;
    logic        vga_draw, halted, trapped;
    logic [15:0] retired;
`ifdef SEQUENCER_STEP_EN
    logic        step = 1'b0;
    always #20 step = ~step;
`endif

    always #5 clock = ~clock;

    instruction_sequencer #(.ALU_PASS(4'h0)) dut (
        .clock(clock), .resetn(resetn),
`ifdef SEQUENCER_STEP_EN
        .step(step),
`endif
        .current_instruction(current_instruction),
        .zeroflag(zeroflag), .signflag(signflag),
        .program_counter_increment(program_counter_increment),
        .alu_op(alu_op), .alu_a_select(alu_a_select),
        .alu_b_select(alu_b_select), .alu_out_select(alu_out_select),
        .alu_a_source(alu_a_source), .alu_b_source(alu_b_source),
        .alu_a_altern(alu_a_altern), .alu_b_altern(alu_b_altern),
        .alu_load_src(alu_load_src), .alu_store_to_mem(alu_store_to_mem),
        .alu_store_to_stk(alu_store_to_stk),
        .vga_color_select(vga_color_select), .vga_coord_select(vga_coord_select),
        .vga_draw(vga_draw), .halted(halted), .trapped(trapped),
        .retired(retired)
    );

    typedef struct {
        logic [255:0] regs;
        int unsigned  cpi;
        logic [15:0]  ret;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;

    logic [15:0] rf[16];
    logic [15:0] dmem[256];
    logic [15:0] stk[16];
    logic [15:0] imem[256];
    logic [3:0]  sp;
    logic [15:0] dp_a, dp_b, dp_c;
    logic [63:0] ctl_bus;

    int unsigned store_cnt, store_run, store_max, draw_cnt, draw_run, draw_max;
    logic [15:0] store_addr;
    logic [3:0]  draw_color, draw_coord;

    assign ctl_bus = {program_counter_increment, alu_op, alu_a_select, alu_b_select,
                      alu_out_select, alu_a_source, alu_b_source, alu_a_altern,
                      alu_b_altern, alu_load_src, alu_store_to_mem, alu_store_to_stk,
                      vga_color_select, vga_coord_select, vga_draw};

    assign current_instruction = imem[rf[0][7:0]];

    always_comb begin
        zeroflag = '0;
        signflag = '0;
        for (int i = 0; i < 16; i++) begin
            zeroflag[i] = (rf[i] == 16'h0000);
            signflag[i] = rf[i][15];
        end
    end

    function automatic logic [15:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
        case (op)
            4'h0:    return a;
            4'h1:    return a + b;
            4'h2:    return a - b;
            4'h3:    return a & b;
            4'h4:    return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [255:0] pack_rf(input logic [15:0] a[16]);
        logic [255:0] p;
        for (int i = 0; i < 16; i++) p[i*16 +: 16] = a[i];
        return p;
    endfunction

    // Datapath samples the controls on the negedge.
    always @(negedge clock) begin
        dp_a = alu_a_source ? alu_a_altern : rf[alu_a_select];
        dp_b = alu_b_source ? alu_b_altern : rf[alu_b_select];
        dp_c = alu_f(alu_op, dp_a, dp_b);
        if (alu_store_to_mem) dmem[dp_c[7:0]] = rf[alu_out_select];
        if (alu_store_to_stk) begin
            stk[sp] = rf[alu_out_select];
            sp = sp + 4'd1;
        end
        case (alu_load_src)
            2'b01: rf[alu_out_select] = dp_c;
            2'b10: rf[alu_out_select] = dmem[dp_c[7:0]];
            2'b11: begin
                sp = sp - 4'd1;
                rf[alu_out_select] = stk[sp];
            end
            default: ;
        endcase
        if (program_counter_increment) rf[0] = rf[0] + 16'd1;
    end

    task automatic clear_env();
        for (int i = 0; i < 16; i++) begin rf[i] = '0; stk[i] = '0; end
        for (int i = 0; i < 256; i++) begin dmem[i] = '0; imem[i] = '0; end
        sp = '0;
        store_cnt = 0; store_run = 0; store_max = 0; store_addr = '0;
        draw_cnt = 0; draw_run = 0; draw_max = 0; draw_color = '0; draw_coord = '0;
    endtask

    // Instruction-level reference: push the expected state after each retire.
    task automatic ref_build(input int unsigned max_instr);
        logic [15:0] r[16];
        logic [15:0] m[256];
        logic [15:0] s[16];
        logic [3:0]  p, rd, rs, lo;
        logic [15:0] ins;
        int unsigned cpi;
        bit          stop;
        exp_t        e;
        for (int i = 0; i < 16; i++) begin r[i] = rf[i]; s[i] = stk[i]; end
        for (int i = 0; i < 256; i++) m[i] = dmem[i];
        p = sp;
        sb.delete();
        for (int unsigned n = 0; n < max_instr; n++) begin
            ins = imem[r[0][7:0]];
            rd = ins[11:8]; rs = ins[7:4]; lo = ins[3:0];
            cpi = 2; stop = 1'b0;
            case (ins[15:12])
                4'h1: begin r[rd] = alu_f(lo, r[rd], r[rs]); r[0] = r[0] + 16'd1; end
                4'h2: begin r[rd] = alu_f(lo, r[rd], {12'h000, rs}); r[0] = r[0] + 16'd1; end
                4'h3: begin r[rd] = {8'h00, ins[7:0]}; r[0] = r[0] + 16'd1; end
                4'h4: begin r[rd] = m[r[rs][7:0]]; r[0] = r[0] + 16'd1; cpi = 3; end
                4'h5: begin m[r[rs][7:0]] = r[rd]; r[0] = r[0] + 16'd1; end
                4'h6: begin p = p - 4'd1; r[rd] = s[p]; r[0] = r[0] + 16'd1; cpi = 3; end
                4'h7: begin s[p] = r[rd]; p = p + 4'd1; r[0] = r[0] + 16'd1; end
                4'h8: r[0] = (r[rd] == 16'h0000) ? r[rs] : r[0] + 16'd1;
                4'h9: r[0] = r[rd][15] ? r[rs] : r[0] + 16'd1;
                4'hA: r[0] = r[rs];
                4'hB: r[0] = r[0] + 16'd1;
                default: stop = 1'b1;
            endcase
            if (stop) break;
            e.regs = pack_rf(r);
            e.cpi  = cpi;
            e.ret  = 16'(n + 1);
            sb.push_back(e);
        end
    endtask

    // Release reset and compare against the scoreboard at each retire.
    task automatic run_program(input int unsigned max_cycles);
        int unsigned since;
        logic [15:0] prev_ret;
        exp_t        e;
        @(negedge clock);
        resetn = 1'b1;
        since = 0;
        prev_ret = retired;
        for (int unsigned cyc = 0; cyc < max_cycles; cyc++) begin
            @(posedge clock);
            #1;
            since++;
            if (alu_store_to_mem === 1'b1) begin
                store_cnt++; store_run++;
                store_addr = alu_f(alu_op, alu_a_source ? alu_a_altern : rf[alu_a_select],
                                   alu_b_source ? alu_b_altern : rf[alu_b_select]);
                if (store_run > store_max) store_max = store_run;
            end else store_run = 0;
            if (vga_draw === 1'b1) begin
                draw_cnt++; draw_run++;
                draw_color = vga_color_select; draw_coord = vga_coord_select;
                if (draw_run > draw_max) draw_max = draw_run;
            end else draw_run = 0;
            if (retired !== prev_ret) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow retired=%h expected no retire", retired);
                end else begin
                    e = sb.pop_front();
                    if (pack_rf(rf) !== e.regs) begin
                        errors++;
                        $display("FAIL regs_at_retire%0d got %h want %h", e.ret, pack_rf(rf), e.regs);
                    end
                    checks++;
                    if (since != e.cpi) begin
                        errors++;
                        $display("FAIL cpi_at_retire%0d got %0d want %0d", e.ret, since, e.cpi);
                    end
                    checks++;
                    if (retired !== e.ret) begin
                        errors++;
                        $display("FAIL retired_count got %h want %h", retired, e.ret);
                    end
                end
                prev_ret = retired;
                since = 0;
            end
            if (halted === 1'b1 || trapped === 1'b1) break;
        end
        checks++;
        if (!(halted === 1'b1 || trapped === 1'b1)) begin
            errors++;
            $display("FAIL run_timeout halted=%b trapped=%b want one set", halted, trapped);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d entries want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_env();
        repeat (3) @(negedge clock);
        checks++;
        if (ctl_bus !== 64'h0) begin
            errors++; $display("FAIL reset_ctl got %h want 0", ctl_bus);
        end
        checks++;
        if ({retired, halted, trapped} !== 18'h0) begin
            errors++;
            $display("FAIL reset_status got ret=%h h=%b t=%b want 0", retired, halted, trapped);
        end
    endtask

    task automatic test_ldi_alu();
        resetn = 1'b0;
        clear_env();
        rf[4] = 16'h1234;
        imem[0] = 16'h335A;   // LDI r3,#5A
        imem[1] = 16'h1341;   // ALU r3,r4 add
        ref_build(10);
        run_program(60);
        checks++;
        if (rf[3] !== 16'h128E) begin
            errors++; $display("FAIL alu_add_r3 got %h want 128e", rf[3]);
        end
        checks++;
        if ({halted, rf[0], retired} !== {1'b1, 16'd2, 16'd2}) begin
            errors++;
            $display("FAIL halt_state got h=%b pc=%h ret=%h want 1/2/2", halted, rf[0], retired);
        end
    endtask

    task automatic test_store_load();
        resetn = 1'b0;
        clear_env();
        rf[1] = 16'h0040; rf[2] = 16'hBEEF; rf[5] = 16'h0001;
        imem[0] = 16'h5210;   // ST r2 -> [r1]
        imem[1] = 16'h4510;   // LD r5 <- [r1]
        ref_build(10);
        run_program(60);
        checks++;
        if ({store_cnt, store_max} !== {32'd1, 32'd1}) begin
            errors++; $display("FAIL store_strobe got cnt=%0d run=%0d want 1/1", store_cnt, store_max);
        end
        checks++;
        if (store_addr !== 16'h0040) begin
            errors++; $display("FAIL store_addr got %h want 0040", store_addr);
        end
        checks++;
        if (rf[5] !== 16'hBEEF) begin
            errors++; $display("FAIL ld_value got %h want beef", rf[5]);
        end
    endtask

    task automatic test_jumps();
        resetn = 1'b0;
        clear_env();
        rf[2] = 16'hCAFE; rf[6] = 16'h0000; rf[7] = 16'h0010; rf[8] = 16'h0001;
        rf[9] = 16'h8000; rf[10] = 16'h0020; rf[11] = 16'h0030; rf[13] = 16'h0005;
        imem[8'h00] = 16'h8670;  // JZ r6,r7 taken
        imem[8'h10] = 16'h8870;  // JZ r8,r7 not taken
        imem[8'h11] = 16'h99A0;  // JN r9,r10 taken
        imem[8'h20] = 16'hA0B0;  // JMP r11
        imem[8'h30] = 16'h7200;  // PUSH r2
        imem[8'h31] = 16'h6C00;  // POP r12
        imem[8'h32] = 16'hB340;  // DRAW r3,r4
        imem[8'h33] = 16'h2D31;  // ALUI r13,#3 add
        imem[8'h34] = 16'h3040;  // LDI r0,#40 -> PC 41
        ref_build(20);
        run_program(100);
        checks++;
        if ({rf[0], rf[12], rf[13]} !== {16'h0041, 16'hCAFE, 16'h0008}) begin
            errors++;
            $display("FAIL jump_final got pc=%h r12=%h r13=%h want 0041/cafe/0008", rf[0], rf[12], rf[13]);
        end
        checks++;
        if ({draw_cnt, draw_max, draw_color, draw_coord} !== {32'd1, 32'd1, 4'd3, 4'd4}) begin
            errors++;
            $display("FAIL draw_strobe got cnt=%0d run=%0d col=%h crd=%h want 1/1/3/4",
                     draw_cnt, draw_max, draw_color, draw_coord);
        end
        checks++;
        if (retired !== 16'd9) begin
            errors++; $display("FAIL jump_retired got %0d want 9", retired);
        end
    endtask

    task automatic test_trap();
        logic [15:0] pc0, ret0;
        bit moved;
        resetn = 1'b0;
        clear_env();
        imem[0] = 16'h3101;   // LDI r1,#1
        imem[1] = 16'hD000;   // illegal
        ref_build(10);
        run_program(60);
        checks++;
        if ({trapped, halted, retired, rf[0]} !== {1'b1, 1'b0, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL trap_state got t=%b h=%b ret=%h pc=%h want 1/0/1/1", trapped, halted, retired, rf[0]);
        end
        pc0 = rf[0]; ret0 = retired; moved = 1'b0;
        repeat (20) begin
            @(posedge clock); #1;
            if (rf[0] !== pc0 || retired !== ret0 || ctl_bus !== 64'h0) moved = 1'b1;
        end
        checks++;
        if (moved) begin
            errors++; $display("FAIL trap_frozen got pc=%h ret=%h want %h/%h", rf[0], retired, pc0, ret0);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({trapped, retired} !== 17'h0) begin
            errors++; $display("FAIL trap_reset got t=%b ret=%h want 0/0", trapped, retired);
        end
    endtask

    task automatic test_reset_in_wait();
        resetn = 1'b0;
        clear_env();
        rf[1] = 16'h0040; rf[5] = 16'h1111; dmem[8'h40] = 16'h7777;
        imem[0] = 16'h4510;   // LD r5 <- [r1]
        @(negedge clock);
        resetn = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        checks++;
        if (alu_load_src !== 2'b10) begin
            errors++; $display("FAIL wait_entry got load_src=%b want 10", alu_load_src);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (ctl_bus !== 64'h0) begin
            errors++; $display("FAIL reset_in_wait_ctl got %h want 0", ctl_bus);
        end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if ({rf[5], rf[0]} !== {16'h1111, 16'h0000}) begin
            errors++; $display("FAIL aborted_load got r5=%h pc=%h want 1111/0000", rf[5], rf[0]);
        end
        ref_build(10);
        run_program(60);
        checks++;
        if (rf[5] !== 16'h7777) begin
            errors++; $display("FAIL reload_after_reset got %h want 7777", rf[5]);
        end
    endtask

    initial begin
        test_reset();
        test_ldi_alu();
        test_store_load();
        test_jumps();
        test_trap();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
